// File: rtl/iecdrv_pkg.sv
// Shared types and the drive ROM address mask for the drive ROM fetch scheduler.
// The mask covers the low 15 address bits; wider addresses pass their upper bits through.
package iecdrv_pkg;

  localparam int ROM_MASK_W = 15;
  localparam int IDX_W      = 2;   // enough for up to 4 drive requesters

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    HOST  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // One-deep record of which drive owns the byte arriving on mem_q next cycle.
  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } tag_t;

  // A14 exists only on 32K ROMs; A13 exists on 16K+ ROMs or when the standard ROM is selected.
  function automatic logic [ROM_MASK_W-1:0] rom_mask(input logic [ROM_MASK_W-1:0] a,
                                                     input logic [1:0]            rom_sz,
                                                     input logic                  stdrom);
    return {a[14] & rom_sz[1], a[13] & (rom_sz[0] | stdrom), a[12:0]};
  endfunction

endpackage

// File: rtl/iecdrv_rom_sched_if.sv
// Host read port and shared synchronous ROM bus of the drive ROM scheduler.
// The scheduler uses the slave modport; the host/ROM side uses master.
interface iecdrv_rom_sched_if #(
  parameter int AW = 15
);
  logic          host_req;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_data;
  logic          host_ack;
  logic [AW-1:0] mem_a;
  logic [7:0]    mem_q;

  modport slave (
    input  host_req, host_addr, mem_q,
    output host_data, host_ack, mem_a
  );

  modport master (
    output host_req, host_addr, mem_q,
    input  host_data, host_ack, mem_a
  );
endinterface

// File: rtl/iecdrv_rom_mask.sv
// Combinational ROM-size address mask applied to drive fetch addresses.
module iecdrv_rom_mask
  import iecdrv_pkg::*;
#(
  parameter int AW = 15
) (
  input  logic [AW-1:0] addr_i,
  input  logic [1:0]    rom_sz,
  input  logic          stdrom,
  output logic [AW-1:0] addr_o
);

  always_comb begin
    addr_o                 = addr_i;
    addr_o[ROM_MASK_W-1:0] = rom_mask(addr_i[ROM_MASK_W-1:0], rom_sz, stdrom);
  end

endmodule

// File: rtl/iecdrv_rom_sched.sv
// Time-multiplexes one synchronous drive ROM between NDR drive CPUs and a low-priority host
// read port; every ph2_f phase serves the requesting drives in index order, then one host read.
module iecdrv_rom_sched
  import iecdrv_pkg::*;
#(
  parameter int NDR = 2,
  parameter int AW  = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ph2_f,
  input  logic [1:0]             rom_sz,
  input  logic                   stdrom,
  input  logic [NDR-1:0]         drv_req,
  input  logic [NDR-1:0][AW-1:0] drv_addr,
  output logic [NDR-1:0][7:0]    drv_data,
  output logic [NDR-1:0]         drv_valid,
  output logic                   overrun,
  iecdrv_rom_sched_if.slave      bus
);

  state_e                 state_q, state_d;
  logic [NDR-1:0]         pend_q, pend_d;
  logic [NDR-1:0][AW-1:0] alat_q, alat_d;
  tag_t                   tag_q, tag_d;
  logic                   host_vld_q, host_vld_d;
  logic                   overrun_q, overrun_d;
  logic [AW-1:0]          mem_a_q, mem_a_d;
  logic [NDR-1:0][7:0]    drv_data_q, drv_data_d;
  logic [7:0]             host_data_q, host_data_d;

  logic                   sel_hit;
  logic [IDX_W-1:0]       sel_idx;
  logic [NDR-1:0]         sel_oh;
  logic [AW-1:0]          sel_addr;
  logic [AW-1:0]          drv_mem_a;
  logic                   host_go;
  state_e                 after_drv;

  // Lowest-index pending drive wins: scan downward so the last hit is the lowest.
  always_comb begin
    sel_hit  = 1'b0;
    sel_idx  = '0;
    sel_oh   = '0;
    sel_addr = '0;
    for (int i = NDR - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_hit  = 1'b1;
        sel_idx  = IDX_W'(i);
        sel_oh   = NDR'(1) << i;
        sel_addr = alat_q[i];
      end
    end
  end

  iecdrv_rom_mask #(.AW(AW)) u_mask (
    .addr_i (sel_addr),
    .rom_sz (rom_sz),
    .stdrom (stdrom),
    .addr_o (drv_mem_a)
  );

  // A host read still waiting for its ack must not be issued twice.
  assign host_go   = bus.host_req && !host_vld_q;
  assign after_drv = host_go ? HOST : DRAIN;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    pend_d     = pend_q;
    alat_d     = alat_q;
    tag_d      = '0;
    host_vld_d = 1'b0;
    overrun_d  = overrun_q;
    mem_a_d    = mem_a_q;

    unique case (state_q)
      IDLE: ;
      SERVE: begin
        if (sel_hit) begin
          mem_a_d = drv_mem_a;
          tag_d   = '{vld: 1'b1, idx: sel_idx};
          pend_d  = pend_q & ~sel_oh;
        end
        if ((pend_q & ~sel_oh) == '0) state_d = after_drv;
      end
      HOST: begin
        mem_a_d    = bus.host_addr;
        host_vld_d = 1'b1;
        state_d    = DRAIN;
      end
      DRAIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new phase replaces any unissued requests; the in-flight tag is left to retire.
    if (ph2_f) begin
      if (state_q != IDLE) overrun_d = 1'b1;
      pend_d  = drv_req;
      alat_d  = drv_addr;
      state_d = (drv_req != '0) ? SERVE : after_drv;
    end
  end

  always_comb begin
    drv_data_d = drv_data_q;
    drv_valid  = '0;
    for (int i = 0; i < NDR; i++) begin
      if (tag_q.vld && tag_q.idx == IDX_W'(i)) begin
        drv_data_d[i] = bus.mem_q;
        drv_valid[i]  = 1'b1;
      end
    end
    host_data_d = host_vld_q ? bus.mem_q : host_data_q;
  end

  assign drv_data      = drv_data_d;
  assign overrun       = overrun_q;
  assign bus.mem_a     = mem_a_d;
  assign bus.host_ack  = host_vld_q;
  assign bus.host_data = host_data_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      alat_q      <= '0;
      tag_q       <= '0;
      host_vld_q  <= 1'b0;
      overrun_q   <= 1'b0;
      mem_a_q     <= '0;
      drv_data_q  <= '1;
      host_data_q <= 8'hFF;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      alat_q      <= alat_d;
      tag_q       <= tag_d;
      host_vld_q  <= host_vld_d;
      overrun_q   <= overrun_d;
      mem_a_q     <= mem_a_d;
      drv_data_q  <= drv_data_d;
      host_data_q <= host_data_d;
    end
  end

endmodule

// File: tb/tb_iecdrv_rom_sched.sv
// Directed bench for iecdrv_rom_sched with four drives and a behavioural synchronous ROM.
module tb_iecdrv_rom_sched;
  import iecdrv_pkg::*;

  localparam int NDR = 4;
  localparam int AW  = 15;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   ph2_f;
  logic [1:0]             rom_sz;
  logic                   stdrom;
  logic [NDR-1:0]         drv_req;
  logic [NDR-1:0][AW-1:0] drv_addr;
  logic [NDR-1:0][7:0]    drv_data;
  logic [NDR-1:0]         drv_valid;
  logic                   overrun;

  int n_vec = 0;
  int n_err = 0;

  iecdrv_rom_sched_if #(.AW(AW)) bus ();

  iecdrv_rom_sched #(.NDR(NDR), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .ph2_f     (ph2_f),
    .rom_sz    (rom_sz),
    .stdrom    (stdrom),
    .drv_req   (drv_req),
    .drv_addr  (drv_addr),
    .drv_data  (drv_data),
    .drv_valid (drv_valid),
    .overrun   (overrun),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input logic [AW-1:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'hA5;
  endfunction

  always @(posedge clk) bus.mem_q <= rom_f(bus.mem_a);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addrs(input logic [AW-1:0] a0, a1, a2, a3);
    drv_addr[0] = a0;
    drv_addr[1] = a1;
    drv_addr[2] = a2;
    drv_addr[3] = a3;
  endtask

  // Raises ph2_f for one cycle; returns during cycle 1 of the new phase.
  task automatic start_phase(input logic [NDR-1:0] req);
    drv_req = req;
    ph2_f   = 1'b1;
    tick();
    ph2_f   = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] exp_a [4];
    logic [1:0]    m_sz  [4];
    logic          m_std [4];
    logic [AW-1:0] m_exp [4];
    int acks, ack_c, last_v, vcnt;

    reset = 1'b1; ph2_f = 1'b0; rom_sz = 2'd3; stdrom = 1'b0;
    drv_req = '0; drv_addr = '0; bus.host_req = 1'b0; bus.host_addr = '0;
    repeat (3) tick();
    check("rst_valid", drv_valid, 0);
    check("rst_ack", bus.host_ack, 0);
    check("rst_overrun", overrun, 0);
    check("rst_mem_a", bus.mem_a, 0);
    check("rst_drv_data", drv_data, 32'hFFFF_FFFF);
    check("rst_host_data", bus.host_data, 8'hFF);
    reset = 1'b0;
    repeat (2) tick();

    // All four drives in index order, then drain; mem_a holds in IDLE.
    exp_a = '{15'h0100, 15'h0200, 15'h0300, 15'h0400};
    set_addrs(exp_a[0], exp_a[1], exp_a[2], exp_a[3]);
    start_phase(4'b1111);
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) check($sformatf("order_mem_a_c%0d", k), bus.mem_a, exp_a[k-1]);
      if (k == 6) check("order_mem_a_hold", bus.mem_a, 15'h0400);
      check($sformatf("order_valid_c%0d", k), drv_valid,
            (k >= 2 && k <= 5) ? 32'(1 << (k - 2)) : 32'd0);
      if (k >= 2 && k <= 5)
        check($sformatf("order_data_c%0d", k), drv_data[k-2], rom_f(exp_a[k-2]));
      check($sformatf("order_ack_c%0d", k), bus.host_ack, 0);
      tick();
    end

    // Sparse request: drives 0 and 2 only, back to back.
    set_addrs(15'h0111, 15'h0222, 15'h0333, 15'h0444);
    start_phase(4'b0101);
    check("sparse_mem_a_c1", bus.mem_a, 15'h0111);
    check("sparse_valid_c1", drv_valid, 0);
    tick();
    check("sparse_mem_a_c2", bus.mem_a, 15'h0333);
    check("sparse_valid_c2", drv_valid, 4'b0001);
    check("sparse_data0", drv_data[0], rom_f(15'h0111));
    tick();
    check("sparse_valid_c3", drv_valid, 4'b0100);
    check("sparse_data2", drv_data[2], rom_f(15'h0333));
    tick();
    check("sparse_valid_c4", drv_valid, 0);
    check("sparse_keep1", drv_data[1], rom_f(15'h0200));
    check("sparse_keep3", drv_data[3], rom_f(15'h0400));

    // Address mask across ROM sizes and the standard-ROM override.
    m_sz  = '{2'd0, 2'd0, 2'd2, 2'd1};
    m_std = '{1'b0, 1'b1, 1'b0, 1'b0};
    m_exp = '{15'h1FFF, 15'h3FFF, 15'h5FFF, 15'h3FFF};
    for (int m = 0; m < 4; m++) begin
      rom_sz = m_sz[m];
      stdrom = m_std[m];
      set_addrs(15'h7FFF, 15'h0, 15'h0, 15'h0);
      start_phase(4'b0001);
      check($sformatf("mask_mem_a_%0d", m), bus.mem_a, m_exp[m]);
      tick();
      check($sformatf("mask_valid_%0d", m), drv_valid, 4'b0001);
      check($sformatf("mask_data_%0d", m), drv_data[0], rom_f(m_exp[m]));
      repeat (2) tick();
    end
    stdrom = 1'b0;

    // Host read after the drive fetches, once per phase.
    rom_sz = 2'd3;
    bus.host_req  = 1'b1;
    bus.host_addr = 15'h4ABC;
    set_addrs(15'h0010, 15'h0020, 15'h0, 15'h0);
    start_phase(4'b0011);
    check("host_mem_a_c1", bus.mem_a, 15'h0010);
    tick();
    check("host_valid_c2", drv_valid, 4'b0001);
    check("host_ack_c2", bus.host_ack, 0);
    tick();
    check("host_mem_a_c3", bus.mem_a, 15'h4ABC);
    check("host_valid_c3", drv_valid, 4'b0010);
    check("host_ack_c3", bus.host_ack, 0);
    tick();
    check("host_ack_c4", bus.host_ack, 1);
    check("host_data_c4", bus.host_data, rom_f(15'h4ABC));
    check("host_valid_c4", drv_valid, 0);
    tick();
    check("host_ack_c5", bus.host_ack, 0);
    repeat (3) tick();

    // Second phase, host_req still high and a small ROM: host address is not masked.
    rom_sz = 2'd0;
    acks = 0; ack_c = 0; last_v = 0;
    start_phase(4'b0011);
    for (int k = 1; k <= 10; k++) begin
      if (drv_valid != '0) last_v = k;
      if (bus.host_ack) begin
        acks++;
        ack_c = k;
        check("host2_data", bus.host_data, rom_f(15'h4ABC));
      end
      if (k == 3) check("host2_mem_a_unmasked", bus.mem_a, 15'h4ABC);
      tick();
    end
    check("host2_acks", acks, 1);
    check("host2_ack_cycle", ack_c, 4);
    check("host2_ack_after_valid", 32'(ack_c > last_v), 1);
    check("host2_overrun", overrun, 0);
    bus.host_req = 1'b0;

    // Early ph2_f two clocks into a four-drive schedule.
    rom_sz = 2'd3;
    set_addrs(15'h1001, 15'h1002, 15'h1003, 15'h1004);
    start_phase(4'b1111);
    check("ovr_mem_a_c1", bus.mem_a, 15'h1001);
    tick();
    check("ovr_mem_a_c2", bus.mem_a, 15'h1002);
    check("ovr_valid_c2", drv_valid, 4'b0001);
    set_addrs(15'h2001, 15'h2002, 15'h2003, 15'h2004);
    start_phase(4'b0010);
    check("ovr_flag", overrun, 1);
    check("ovr_inflight_valid", drv_valid, 4'b0010);
    check("ovr_inflight_data", drv_data[1], rom_f(15'h1002));
    check("ovr_new_mem_a", bus.mem_a, 15'h2002);
    tick();
    check("ovr_new_valid", drv_valid, 4'b0010);
    check("ovr_new_data", drv_data[1], rom_f(15'h2002));
    tick();
    check("ovr_idle_valid", drv_valid, 0);
    check("ovr_keep0", drv_data[0], rom_f(15'h1001));
    check("ovr_keep2", drv_data[2], rom_f(15'h0333));
    check("ovr_keep3", drv_data[3], rom_f(15'h0400));
    check("ovr_sticky", overrun, 1);

    // Reset in the middle of SERVE.
    set_addrs(15'h0100, 15'h0200, 15'h0300, 15'h0400);
    start_phase(4'b1111);
    tick();
    reset = 1'b1;
    #1;
    check("mrst_valid", drv_valid, 0);
    check("mrst_mem_a", bus.mem_a, 0);
    check("mrst_overrun", overrun, 0);
    check("mrst_drv_data", drv_data, 32'hFFFF_FFFF);
    check("mrst_host_data", bus.host_data, 8'hFF);
    tick();
    reset = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (drv_valid != '0 || bus.host_ack) vcnt++;
      tick();
    end
    check("mrst_no_pulse", vcnt, 0);
    check("mrst_mem_a_after", bus.mem_a, 0);

    // ph2_f coinciding with the final capture in DRAIN.
    set_addrs(15'h0500, 15'h0600, 15'h0, 15'h0);
    start_phase(4'b0001);
    check("coin_mem_a_c1", bus.mem_a, 15'h0500);
    tick();
    check("coin_valid_c2", drv_valid, 4'b0001);
    check("coin_data0", drv_data[0], rom_f(15'h0500));
    start_phase(4'b0010);
    check("coin_mem_a_c3", bus.mem_a, 15'h0600);
    tick();
    check("coin_valid_c4", drv_valid, 4'b0010);
    check("coin_data1", drv_data[1], rom_f(15'h0600));
    check("coin_keep0", drv_data[0], rom_f(15'h0500));
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iecdrv_rom_sched.md
IECDRV_ROM_SCHED -- requirements
Module: iecdrv_rom_sched

Interface
REQ-001 Parameter NDR, default 2, number of drive requesters; legal range 1..4.
REQ-002 Parameter AW, default 15, ROM address width.
REQ-003 clk  input  1  drive clock, 16MHz; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state.
REQ-005 ph2_f  input  1  one-cycle strobe marking the start of a drive CPU phase.
REQ-006 rom_sz  input  2  ROM size code: bit1 = 32K, bit0 = 16K or larger.
REQ-007 stdrom  input  1  standard-ROM select, forces address bit 13 pass-through.
REQ-008 drv_req  input  NDR  per-drive fetch request, sampled only on ph2_f.
REQ-009 drv_addr  input  NDR x AW  per-drive fetch address, sampled only on ph2_f.
REQ-010 drv_data  output  NDR x 8  per-drive fetched byte, held until the next fetch for that drive.
REQ-011 drv_valid  output  NDR  one-cycle pulse when drv_data[i] updates.
REQ-012 host_req  input  1  level request from the low-priority host/debug read port.
REQ-013 host_addr  input  AW  host read address, stable while host_req is high.
REQ-014 host_data  output  8  host read byte.
REQ-015 host_ack  output  1  one-cycle pulse; host_data is valid in the same cycle.
REQ-016 mem_a  output  AW  address to the shared synchronous ROM.
REQ-017 mem_q  input  8  ROM read data, one clk after mem_a.
REQ-018 overrun  output  1  sticky flag: ph2_f arrived before the schedule completed.

Function
REQ-019 FSM states: IDLE, SERVE, HOST, DRAIN.
REQ-020 On ph2_f, in any state, the block SHALL snapshot drv_req into pend and drv_addr into alat, then enter SERVE.
REQ-021 In SERVE, each cycle the block SHALL issue the lowest-index set pend bit on mem_a, clear that bit, and record the index in a one-deep tag pipeline.
REQ-022 Drives with pend=0 SHALL consume no cycle; with pend all zero, SERVE SHALL go directly to HOST or DRAIN.
REQ-023 Address mask for drive fetches SHALL be {a[14]&rom_sz[1], a[13]&(rom_sz[0]|stdrom), a[12:0]}; host fetches SHALL be unmasked.
REQ-024 One cycle after issue, the block SHALL capture mem_q into drv_data[tag] and pulse drv_valid[tag]; latency from issue to valid SHALL be 1 clk.
REQ-025 When pend empties: if host_req=1 and no host ack is outstanding, go to HOST; otherwise go to DRAIN.
REQ-026 HOST SHALL issue host_addr for exactly one cycle, then go to DRAIN; host_ack and host_data SHALL follow 1 clk later.
REQ-027 DRAIN SHALL last exactly one cycle to retire the final capture, then return to IDLE.
REQ-028 Host access SHALL occur at most once per phase and only after all drive fetches of that phase.
REQ-029 host_req held high SHALL be re-served in later phases, one ack per phase.
REQ-030 If ph2_f arrives while the state is not IDLE, the block SHALL set overrun, abandon the unissued pend bits, and still complete the in-flight capture.
REQ-031 If ph2_f and the final-cycle capture occur together, both SHALL take effect.
REQ-032 In IDLE, mem_a SHALL hold its last value.
REQ-033 Worst-case schedule is NDR+2 cycles (NDR fetches, host, drain) and SHALL fit within a 16-clk phase.

Reset
REQ-034 While reset is asserted: state=IDLE; pend=0; drv_valid=0; host_ack=0; overrun=0; mem_a=0; drv_data=8'hFF; host_data=8'hFF.
REQ-035 Reset asserted mid-schedule SHALL discard all pending and in-flight fetches with no valid or ack pulse.

Structure
REQ-036 The state enum and the ROM address-mask function SHALL live in the shared package iecdrv_pkg.
REQ-037 One sub-module, iecdrv_rom_mask (combinational mask), SHALL be used for the drive address path.

Verification
REQ-038 NDR=4, all requests set, addresses 0x0100/0x0200/0x0300/0x0400, rom_sz=3 -> mem_a follows that order on cycles 1..4 after ph2_f; drv_valid pulses on cycles 2..5.
REQ-039 drv_req=4'b0101 -> only drives 0 and 2 are fetched, on consecutive cycles; drv_data[1] and drv_data[3] are unchanged.
REQ-040 rom_sz=0, stdrom=0, addr=0x7FFF -> mem_a=0x1FFF; with stdrom=1 -> mem_a=0x3FFF.
REQ-041 host_req held high with addr 0x4ABC, drives active -> host_ack pulses once per phase, after the last drv_valid, with host_data equal to ROM[0x4ABC].
REQ-042 ph2_f re-asserted 2 clks after a 4-request ph2_f -> overrun=1, the in-flight capture completes, and the new snapshot is served.
REQ-043 reset asserted during SERVE -> outputs reach their reset values asynchronously, and no drv_valid follows.
